// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Multi-cycle signed integer divider for the datapath ALU. Non-restoring
//   shift/subtract, one quotient bit per clock. The result packs the remainder
//   in the high half and the quotient in the low half, matching the 64-bit
//   layout that feeds the Z register.
//
//   Handshake: the control unit raises start while the divider is idle; the
//   operands are captured on that edge. done pulses for one cycle when
//   Result_div becomes valid. Result_div then holds until the next done or
//   reset. start while busy is ignored. start during the done cycle is a new
//   request.
//
//   Timing: a normal divide produces done WIDTH+1 edges after the accept edge.
//   A divide by zero produces done on the accept edge itself.
//
//   Optional build macro: DIVIDER_UNSIGNED_EN
//     This macro adds the div_unsigned input, which is sampled at accept.
//     When div_unsigned is 1, the operands are taken as unsigned magnitudes.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   start        in   request, sampled only when idle
//   A_div        in   dividend (two's complement)
//   B_div        in   divisor (two's complement)
//   div_unsigned in   unsigned mode select (only with DIVIDER_UNSIGNED_EN)
//   Result_div   out  {remainder, quotient}
//   busy         out  operation in progress
//   done         out  one-cycle completion pulse
//   div_by_zero  out  pulses with done when the divisor was zero
//
//   The FSM state is visible as the internal signal 'state' (state_t).
// -----------------------------------------------------------------------------
module divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A_div,
  input  logic [WIDTH-1:0]   B_div,
`ifdef DIVIDER_UNSIGNED_EN
  input  logic               div_unsigned,
`endif
  output logic [2*WIDTH-1:0] Result_div,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // The partial remainder carries one extra bit so that its sign is available
  // directly.
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b_mag;
  logic             sign_a;
  logic             sign_b;
  logic [CW-1:0]    cnt;

  // ---------------------------------------------------------------------------
  // Operand conditioning at accept
  // ---------------------------------------------------------------------------
  logic             is_signed;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag_in;
  logic             b_zero;

`ifdef DIVIDER_UNSIGNED_EN
  assign is_signed = ~div_unsigned;
`else
  assign is_signed = 1'b1;
`endif

  assign neg_a = is_signed & A_div[WIDTH-1];
  assign neg_b = is_signed & B_div[WIDTH-1];
  // The most negative value has magnitude 2^(WIDTH-1), which still fits
  // unsigned in WIDTH bits.
  assign a_mag_in = neg_a ? (~A_div + 1'b1) : A_div;
  assign b_mag_in = neg_b ? (~B_div + 1'b1) : B_div;
  assign b_zero   = (B_div == '0);

  // ---------------------------------------------------------------------------
  // One non-restoring step.
  // The add/subtract choice uses the sign of P before the shift. The shifted
  // value can exceed the P register width when the divisor is large. However,
  // the sum after the add or subtract always lands back in [-|B|, |B|), so the
  // wrapped arithmetic still gives the correct result.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] q_step;

  always_comb begin
    p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
    if (p[WIDTH]) begin
      p_step = p_shift + {1'b0, b_mag};
    end else begin
      p_step = p_shift - {1'b0, b_mag};
    end
    q_step = {q[WIDTH-2:0], ~p_step[WIDTH]};
  end

  // ---------------------------------------------------------------------------
  // Final correction: restore a negative remainder, then apply the signs.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   p_fix;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] rem_final;
  logic [WIDTH-1:0] quo_final;

  always_comb begin
    p_fix     = p[WIDTH] ? (p + {1'b0, b_mag}) : p;
    rem_mag   = p_fix[WIDTH-1:0];
    rem_final = sign_a ? (~rem_mag + 1'b1) : rem_mag;
    quo_final = (sign_a ^ sign_b) ? (~q + 1'b1) : q;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !b_zero) state_next = ITER;
      ITER:    if (cnt == LAST)      state_next = FIX;
      FIX:                           state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      p           <= '0;
      q           <= '0;
      b_mag       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      cnt         <= '0;
      Result_div  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (b_zero) begin
              // Divide by zero: answer immediately without entering ITER.
              Result_div  <= {A_div, {WIDTH{1'b1}}};
              done        <= 1'b1;
              div_by_zero <= 1'b1;
            end else begin
              p      <= '0;
              q      <= a_mag_in;
              b_mag  <= b_mag_in;
              sign_a <= neg_a;
              sign_b <= neg_b;
              cnt    <= '0;
              busy   <= 1'b1;
            end
          end
        end
        ITER: begin
          p   <= p_step;
          q   <= q_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          Result_div <= {rem_final, quo_final};
          done       <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//   Self-checking bench for divider (WIDTH=32). It runs the following
//   sequences:
//     - a table of directed vectors with hand-computed results;
//     - hand-written sequences for reset abort, ignored start and back-to-back
//       accept;
//     - randomized operations checked against a reference model that uses
//       plain integer division.
//   For every operation the bench checks:
//     - Result_div and div_by_zero;
//     - the latency in edges after accept;
//     - the number of busy cycles;
//     - that busy is low at done.
//   If DIVIDER_UNSIGNED_EN is defined, the bench adds the unsigned-mode vectors.
// -----------------------------------------------------------------------------
module tb_divider;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;
`ifdef DIVIDER_UNSIGNED_EN
  localparam bit UNS_EN = 1'b1;
`else
  localparam bit UNS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [WIDTH-1:0]  A_div;
  logic [WIDTH-1:0]  B_div;
  logic              div_unsigned;
  logic [63:0]       Result_div;
  logic              busy;
  logic              done;
  logic              div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  divider #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .A_div        (A_div),
    .B_div        (B_div),
`ifdef DIVIDER_UNSIGNED_EN
    .div_unsigned (div_unsigned),
`endif
    .Result_div   (Result_div),
    .busy         (busy),
    .done         (done),
    .div_by_zero  (div_by_zero)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: truncating integer division on wide integers
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic uns);
    longint      sa, sb, sq, sr;
    logic [63:0] q64, r64;
    logic [31:0] uq, ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (uns) begin
      uq = a / b;
      ur = a % b;
      return {ur, uq};
    end
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    sq  = sa / sb;
    sr  = sa % sb;
    q64 = sq;
    r64 = sr;
    return {r64[31:0], q64[31:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic uns);
    start        = 1'b1;
    A_div        = a;
    B_div        = b;
    div_unsigned = uns & UNS_EN;
  endtask

  // The caller must have already called drive_start.
  // The next edge is the accept edge. This task follows the operation until
  // done and then checks the outcome.
  // If pulse_at >= 0, start is raised again for one edge when edges == pulse_at.
  task automatic finish_op(input string name, input logic [63:0] exp,
                           input logic exp_dz, input int pulse_at);
    int edges;
    int busy_n;
    bit dz_bad;
    edges  = 0;
    busy_n = 0;
    dz_bad = 0;
    @(posedge clk); #1;
    start = 1'b0;
    A_div = $urandom;
    B_div = $urandom;
    while (!done && edges <= 3 * LAT) begin
      if (div_by_zero) dz_bad = 1;
      if (busy) busy_n++;
      if (edges == pulse_at) begin
        start = 1'b1;
        A_div = 32'd9;
        B_div = 32'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done after %0d edges, expected %0d", name, edges,
               exp_dz ? 0 : LAT);
      return;
    end
    check({name, "_result"},  Result_div,          exp);
    check({name, "_dz"},      64'(div_by_zero),    64'(exp_dz));
    check({name, "_latency"}, 64'(edges),          64'(exp_dz ? 0 : LAT));
    check({name, "_busy_at_done"}, 64'(busy),      64'd0);
    check({name, "_busy_cycles"},  64'(busy_n),    64'(exp_dz ? 0 : LAT));
    check({name, "_dz_without_done"}, 64'(dz_bad), 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        uns;
    logic [63:0] exp;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] a, b;
    logic        u;
    logic [63:0] exp;
    bit          bad;

    vecs.push_back('{32'd100,        32'd7,          1'b0, {32'd2,          32'd14},         1'b0});
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b0, {32'hFFFF_FFFF,  32'hFFFF_FFFD},  1'b0});
    vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b0, {32'd1,          32'hFFFF_FFFD},  1'b0});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'd0,          32'h8000_0000},  1'b0});
    vecs.push_back('{32'd5,          32'd0,          1'b0, {32'd5,          32'hFFFF_FFFF},  1'b1});
    vecs.push_back('{32'd0,          32'd5,          1'b0, {32'd0,          32'd0},          1'b0});
    vecs.push_back('{32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b0, {32'hFFFF_FFFE,  32'd14},         1'b0});
    vecs.push_back('{32'h7FFF_FFFF,  32'd1,          1'b0, {32'd0,          32'h7FFF_FFFF},  1'b0});
    vecs.push_back('{32'h8000_0000,  32'd1,          1'b0, {32'd0,          32'h8000_0000},  1'b0});
    vecs.push_back('{32'd1,          32'h8000_0000,  1'b0, {32'd1,          32'd0},          1'b0});
    vecs.push_back('{32'h8000_0000,  32'h8000_0000,  1'b0, {32'd0,          32'd1},          1'b0});
    vecs.push_back('{32'hFFFF_FFFB,  32'd0,          1'b0, {32'hFFFF_FFFB,  32'hFFFF_FFFF},  1'b1});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, {32'd0,          32'd1},          1'b0});
`ifdef DIVIDER_UNSIGNED_EN
    vecs.push_back('{32'hFFFF_FFFF,  32'd2,          1'b1, {32'd1,          32'h7FFF_FFFF},  1'b0});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h8000_0000,  32'd0},          1'b0});
    vecs.push_back('{32'd0,          32'd0,          1'b1, {32'd0,          32'hFFFF_FFFF},  1'b1});
`endif

    // Reset
    reset = 1'b1;
    start = 1'b0;
    A_div = '0;
    B_div = '0;
    div_unsigned = 1'b0;
    idle_cycles(3);
    check("reset_result", Result_div,         64'd0);
    check("reset_busy",   64'(busy),          64'd0);
    check("reset_done",   64'(done),          64'd0);
    check("reset_dz",     64'(div_by_zero),   64'd0);
    reset = 1'b0;

    // Table vectors: even entries follow back-to-back, odd entries after a gap
    for (int i = 0; i < vecs.size(); i++) begin
      if (i % 2 == 1) idle_cycles(1);
      drive_start(vecs[i].a, vecs[i].b, vecs[i].uns);
      finish_op($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp_dz, -1);
    end
    idle_cycles(2);

    // Reset at iteration 10 aborts the operation
    drive_start(32'd100, 32'd7, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    idle_cycles(9);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_busy",   64'(busy), 64'd0);
    check("abort_done",   64'(done), 64'd0);
    check("abort_result", Result_div, 64'd0);
    reset = 1'b0;
    bad = 0;
    repeat (2 * LAT) begin
      @(posedge clk); #1;
      if (done || busy) bad = 1;
    end
    check("abort_no_done", 64'(bad), 64'd0);
    drive_start(32'd9, 32'd3, 1'b0);
    finish_op("after_abort", {32'd0, 32'd3}, 1'b0, -1);
    idle_cycles(1);

    // Start pulsed at iteration 5 is ignored and not queued
    drive_start(32'd100, 32'd7, 1'b0);
    finish_op("ignore_start", {32'd2, 32'd14}, 1'b0, 5);
    bad = 0;
    repeat (2 * LAT) begin
      @(posedge clk); #1;
      if (done || busy) bad = 1;
    end
    check("ignore_no_queue", 64'(bad), 64'd0);

    // Start held during the done cycle is accepted
    drive_start(32'd100, 32'd7, 1'b0);
    finish_op("b2b_first", {32'd2, 32'd14}, 1'b0, -1);
    drive_start(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0);
    finish_op("b2b_second", {32'hFFFF_FFFE, 32'd14}, 1'b0, -1);
    drive_start(32'd5, 32'd0, 1'b0);
    finish_op("b2b_dz", {32'd5, 32'hFFFF_FFFF}, 1'b1, -1);
    drive_start(32'd7, 32'hFFFF_FFFE, 1'b0);
    finish_op("b2b_after_dz", {32'd1, 32'hFFFF_FFFD}, 1'b0, -1);

    // Randomized operations against the model
    for (int k = 0; k < 150; k++) begin
      a = $urandom;
      b = $urandom;
      u = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'd0 - 32'($urandom_range(1, 15));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        4: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      drive_start(a, b, u);
      exp = model(a, b, div_unsigned);
      finish_op($sformatf("rand%0d", k), exp, (b == 32'd0), -1);
      idle_cycles($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
